dnn_image_loader: RTL and testbench

DNN_IMAGE_LOADER -- requirements
Module: dnn_image_loader

---
 rtl/dnn_image_loader.sv | 128 ++++++++++++
 tb/tb_dnn_image_loader.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_image_loader.sv
// Image loader front end for the dnn_top core.
// Collects INPUT_SIZE signed pixels over a valid/ready stream into input_vector,
// pulses start, waits for done (bounded by TIMEOUT) and presents the
// classification on a valid/ready result port.
//   clk, rst          : clock, asynchronous active-high reset
//   pix_*             : pixel stream in (pix_last marks the final pixel)
//   input_vector      : image held for the core
//   start/done        : core handshake, final_digit captured on done
//   res_*             : result out (res_err 00 ok, 01 length, 10 timeout)
//   busy              : high whenever the loader is not accepting pixels
module dnn_image_loader #(
  parameter int INPUT_SIZE = 784,
  parameter int PIXEL_W    = 16,
  parameter int TIMEOUT    = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pix_valid,
  input  logic signed [PIXEL_W-1:0] pix_data,
  input  logic                      pix_last,
  output logic                      pix_ready,
  output logic signed [PIXEL_W-1:0] input_vector [INPUT_SIZE],
  output logic                      start,
  input  logic                      done,
  input  logic [3:0]                final_digit,
  output logic                      res_valid,
  output logic [3:0]                res_digit,
  output logic [1:0]                res_err,
  input  logic                      res_ready,
  output logic                      busy
);

  localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INPUT_SIZE - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [TMO_W-1:0] tmo_cnt;
  logic             xfer;

  assign xfer = (state == LOAD) && pix_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      idx       <= '0;
      tmo_cnt   <= '0;
      start     <= 1'b0;
      res_valid <= 1'b0;
      res_digit <= '0;
      res_err   <= '0;
      busy      <= 1'b0;
      pix_ready <= 1'b1;
    end else begin
      case (state)
        LOAD: begin
          if (xfer) begin
            if (idx == IDX_LAST) begin
              idx       <= '0;
              res_err   <= pix_last ? 2'b00 : 2'b01;
              state     <= START;
              start     <= 1'b1;
              pix_ready <= 1'b0;
              busy      <= 1'b1;
            end else if (pix_last) begin
              // short image: report the length error without running the core
              idx       <= '0;
              res_err   <= 2'b01;
              state     <= RESULT;
              res_valid <= 1'b1;
              pix_ready <= 1'b0;
              busy      <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        START: begin
          start   <= 1'b0;
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (done) begin
            res_digit <= final_digit;
            res_valid <= 1'b1;
            state     <= RESULT;
          end else if (tmo_cnt == TMO_LAST) begin
            // counter would reach TIMEOUT on this cycle
            res_err   <= 2'b10;
            res_digit <= 4'hF;
            res_valid <= 1'b1;
            state     <= RESULT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            pix_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      input_vector <= '{default: '0};
    end else if (xfer) begin
      input_vector[idx] <= pix_data;
    end
  end

endmodule

// File: tb/tb_dnn_image_loader.sv
module tb_dnn_image_loader;

  localparam int N   = 784;
  localparam int W   = 16;
  localparam int TMO = 50;

  logic                clk = 1'b0;
  logic                rst;
  logic                pix_valid;
  logic signed [W-1:0] pix_data;
  logic                pix_last;
  logic                pix_ready;
  logic signed [W-1:0] input_vector [N];
  logic                start;
  logic                done;
  logic [3:0]          final_digit;
  logic                res_valid;
  logic [3:0]          res_digit;
  logic [1:0]          res_err;
  logic                res_ready;
  logic                busy;

  logic       done_resp;
  logic       done_idle;
  logic [3:0] fd_resp;

  assign done        = done_resp | done_idle;
  assign final_digit = done_idle ? 4'd3 : fd_resp;

  always #5 clk = ~clk;

  dnn_image_loader #(
    .INPUT_SIZE(N),
    .PIXEL_W   (W),
    .TIMEOUT   (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_last    (pix_last),
    .pix_ready   (pix_ready),
    .input_vector(input_vector),
    .start       (start),
    .done        (done),
    .final_digit (final_digit),
    .res_valid   (res_valid),
    .res_digit   (res_digit),
    .res_err     (res_err),
    .res_ready   (res_ready),
    .busy        (busy)
  );

  typedef struct {
    logic [3:0] digit;
    logic [1:0] err;
    bit         chk_digit;
    int         lat;
  } exp_t;

  exp_t                res_q[$];
  int                  start_q[$];
  logic signed [W-1:0] ref_img [N];

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         hs_cnt = 0;
  int         st_cnt = 0;
  int         exp_hs = 0;
  int         cfg_done_delay = 20;
  logic [3:0] cfg_digit = 4'd7;
  int         cfg_hold = 0;

  bit         mon_seen = 0;
  int         mon_hold = 0;
  int         mon_last_start = 0;
  logic [3:0] mon_digit;
  logic [1:0] mon_err;
  exp_t       mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < N; i++) begin
      if (input_vector[i] !== ref_img[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL vec_%s: %0d entries differ, first [%0d] got %0d expected %0d",
               name, bad, first, input_vector[first], ref_img[first]);
    end
  endtask

  // Reference: the image buffer holds whatever pixels were accepted since reset.
  task automatic send_pixels(input int n, input int last_at, input bit thr, input int mode);
    logic signed [W-1:0] data;
    exp_t e;
    bit   sent;
    int   guard;
    for (int k = 0; k < n; k++) begin
      case (mode)
        0:       data = W'(k);
        2:       data = W'(k + 1000);
        default: data = W'($urandom);
      endcase
      sent  = 0;
      guard = 0;
      while (!sent) begin
        @(negedge clk);
        pix_valid = thr ? 1'($urandom_range(0, 1)) : 1'b1;
        pix_data  = data;
        pix_last  = (k == last_at);
        if (pix_valid && pix_ready) begin
          sent       = 1;
          ref_img[k] = data;
          if (k == N - 1) begin
            start_q.push_back(cyc + 1);
            if (cfg_done_delay < 0) begin
              e.err   = 2'b10;
              e.digit = 4'hF;
              e.lat   = TMO + 1;
            end else begin
              e.err   = (k == last_at) ? 2'b00 : 2'b01;
              e.digit = cfg_digit;
              e.lat   = cfg_done_delay + 1;
            end
            e.chk_digit = 1;
            res_q.push_back(e);
            exp_hs++;
          end else if (k == last_at) begin
            e.err       = 2'b01;
            e.digit     = 4'h0;
            e.chk_digit = 0;
            e.lat       = -1;
            res_q.push_back(e);
            exp_hs++;
          end
        end else begin
          guard++;
          if (guard > 200) begin
            chk("pixel_accept_timeout", guard, 0);
            pix_valid = 1'b0;
            pix_last  = 1'b0;
            return;
          end
        end
      end
      if (k == last_at && k < N - 1) break;
    end
    @(negedge clk);
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic wait_hs(input int budget);
    int n = 0;
    while (hs_cnt < exp_hs && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("result_handshakes", hs_cnt, exp_hs);
    @(negedge clk);
  endtask

  task automatic wait_start(input int target, input int budget);
    int n = 0;
    while (st_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("start_seen", st_cnt, target);
  endtask

  task automatic check_idle_reset(input string name);
    chk({name, "_start"}, start, 0);
    chk({name, "_res_valid"}, res_valid, 0);
    chk({name, "_res_digit"}, res_digit, 0);
    chk({name, "_res_err"}, res_err, 0);
    chk({name, "_busy"}, busy, 0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    exp_hs    = exp_hs - res_q.size();
    start_q.delete();
    res_q.delete();
    for (int i = 0; i < N; i++) ref_img[i] = '0;
    repeat (n) @(negedge clk);
    check_idle_reset("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_pix_ready", pix_ready, 1);
  endtask

  // Monitor / consumer: pops expectations when the DUT presents start or a result.
  initial begin
    res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_seen  = 0;
        res_ready = 1'b0;
      end else begin
        if (start) begin
          st_cnt++;
          mon_last_start = cyc;
          if (start_q.size() == 0) chk("start_unexpected_at_cycle", cyc, 0);
          else chk("start_cycle", cyc, start_q.pop_front());
        end
        if (res_valid && !mon_seen) begin
          mon_seen  = 1;
          mon_hold  = cfg_hold;
          mon_digit = res_digit;
          mon_err   = res_err;
          if (res_q.size() == 0) begin
            chk("res_valid_unexpected_at_cycle", cyc, 0);
          end else begin
            mon_exp = res_q.pop_front();
            chk("res_err", res_err, mon_exp.err);
            if (mon_exp.chk_digit) chk("res_digit", res_digit, mon_exp.digit);
            if (mon_exp.lat >= 0) chk("res_latency", cyc - mon_last_start, mon_exp.lat);
          end
          if (mon_hold == 0) res_ready = 1'b1;
        end else if (res_valid && mon_seen) begin
          if (!res_ready) begin
            chk("hold_digit", res_digit, mon_digit);
            chk("hold_err", res_err, mon_err);
            if (mon_hold > 0) mon_hold--;
            if (mon_hold == 0) res_ready = 1'b1;
          end else begin
            chk("res_valid_after_handshake", res_valid, 0);
          end
        end else if (!res_valid && mon_seen) begin
          chk("drop_needs_handshake", res_ready, 1);
          res_ready = 1'b0;
          mon_seen  = 0;
          hs_cnt++;
          chk("pix_ready_after_result", pix_ready, 1);
          chk("busy_after_result", busy, 0);
        end
      end
    end
  end

  // Core model: answers each start with done after cfg_done_delay cycles (never if negative).
  initial begin
    done_resp = 1'b0;
    fd_resp   = '0;
    forever begin
      @(negedge clk);
      if (start && !rst && cfg_done_delay >= 0) begin
        repeat (cfg_done_delay) @(negedge clk);
        if (!rst) begin
          done_resp = 1'b1;
          fd_resp   = cfg_digit;
          @(negedge clk);
          done_resp = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got time limit, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int st0;
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_data  = '0;
    pix_last  = 1'b0;
    done_idle = 1'b0;
    for (int i = 0; i < N; i++) ref_img[i] = '0;
    repeat (3) @(negedge clk);
    check_idle_reset("reset");
    check_vec("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("reset_pix_ready", pix_ready, 1);

    // full image, value = index, done after 20 cycles with digit 7
    cfg_done_delay = 20;
    cfg_digit      = 4'd7;
    cfg_hold       = 0;
    send_pixels(N, N - 1, 0, 0);
    wait_hs(300);
    check_vec("index_image");

    // throttled input and a 10-cycle stalled result
    cfg_hold = 10;
    send_pixels(N, N - 1, 1, 1);
    wait_hs(300);
    check_vec("throttled");

    // short image: pix_last on pixel 100
    cfg_hold = 0;
    send_pixels(N, 100, 0, 1);
    wait_hs(100);
    check_vec("short");

    // core never answers: timeout path
    cfg_done_delay = -1;
    send_pixels(N, N - 1, 0, 2);
    wait_hs(300);
    check_vec("timeout");

    // reset in the middle of an image, then a clean image
    send_pixels(400, -1, 0, 1);
    do_reset(2);
    check_vec("after_rst_image");
    cfg_done_delay = 20;
    cfg_digit      = 4'($urandom_range(0, 9));
    send_pixels(N, N - 1, 0, 1);
    wait_hs(300);
    check_vec("after_rst_new");

    // reset while waiting for the core: no result may follow
    cfg_done_delay = -1;
    st0 = st_cnt;
    send_pixels(N, N - 1, 0, 1);
    wait_start(st0 + 1, 50);
    repeat (10) @(negedge clk);
    do_reset(2);
    repeat (80) @(negedge clk);
    chk("no_result_after_wait_rst", hs_cnt, exp_hs);
    chk("res_valid_after_wait_rst", res_valid, 0);
    check_vec("after_wait_rst");

    // done pulses in LOAD are ignored
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      done_idle = 1'b1;
      @(negedge clk);
      done_idle = 1'b0;
      chk("idle_done_res_valid", res_valid, 0);
      chk("idle_done_busy", busy, 0);
      chk("idle_done_pix_ready", pix_ready, 1);
    end

    // pixels offered during WAIT must be refused
    cfg_done_delay = 30;
    cfg_digit      = 4'd5;
    st0 = st_cnt;
    send_pixels(N, N - 1, 0, 1);
    wait_start(st0 + 1, 50);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pix_valid = 1'b1;
      pix_data  = W'($urandom);
      chk("wait_pix_ready", pix_ready, 0);
      chk("wait_busy", busy, 1);
    end
    @(negedge clk);
    pix_valid = 1'b0;
    wait_hs(200);
    check_vec("wait_guard");

    chk("start_q_left", start_q.size(), 0);
    chk("res_q_left", res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
